muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle execution unit for RV32M operations, i.e. ops the decoder flags with isMulDiv and a mulDivCode. It sits in the execute stage beside the ALU. It accepts one operation at a time, produces multiplies in 2 cycles and divides/remainders with a 32-iteration restoring divider. While it works it holds the pipeline through a combinational stall.

## Interface
- DATA_WIDTH, 32: operand/result width; the iteration count equals DATA_WIDTH.
- clk  in  1  clock, all state on rising edge.
- rstN  in  1  asynchronous, active-low reset.
- reqValid  in  1  EX-stage instruction is mul/div (isMulDiv && !isBubble).
- reqCode  in  MulDivCode  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- srcA, srcB  in  DATA_WIDTH  rs1, rs2 values (already forwarded).
- flush  in  1  branch-mispredict/kill of EX; aborts the current operation.
- busy  out  1  stall request to pipeline (combinational).
- resultValid  out  1  one-cycle pulse; result is valid this cycle.
- result  out  DATA_WIDTH  registered result.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - reqValid && !flush → latch code and operands.
  - Next state: DONE if special divide, MUL if MUL family, else DIV.
- Special divide cases are resolved at accept time and written to result directly:
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → srcA.
  - DIV with srcA=0x80000000 and srcB=0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- MUL (one cycle):
  - Form a 2·DATA_WIDTH product with operand sign-extension per code: MULH s×s, MULHSU s×u, MULHU u×u, MUL any.
  - MUL returns the low half; the others return the high half.
  - Next state: DONE.
- DIV:
  - Signed codes (DIV/REM) operate on magnitudes.
  - Remember quotient sign = signA^signB and remainder sign = signA.
  - Each cycle: shift the {remainder, quotient} pair left 1; trial-subtract the divisor; set the quotient bit if the result is non-negative.
  - The counter loads DATA_WIDTH-1 and decrements; on 0 the state goes to DONE.
  - On that transition, negate per the saved signs and select quotient or remainder into result.
- DONE: resultValid=1, then go to IDLE unconditionally; no accept in DONE.
- busy = (state==IDLE) ? (reqValid && !flush) : (state!=DONE).
- flush in any state → IDLE next cycle. No resultValid is issued; result is unchanged. flush beats accept.
- Reset: state=IDLE, counter=0, result=0, all latched operands=0, resultValid=0, busy=0 (with reqValid low).

## Timing
- Cycle 0 is the cycle where IDLE samples reqValid=1.
- resultValid is asserted in cycle:
  - special divide: 1
  - MUL family: 2
  - DIV family: DATA_WIDTH+1 (33).
- busy is high from cycle 0 up to, but excluding, the resultValid cycle. In the resultValid cycle busy=0, so the instruction retires with result.
- Back-to-back operations: the next instruction is sampled in the cycle after DONE (IDLE). A stalled instruction is never accepted twice.
- Reset asserted mid-operation: immediate IDLE; no pulse after release.

## Structure
- Shared OpTypes package:
  - MulDivCode enum (existing).
  - New MulDivState enum (IDLE/MUL/DIV/DONE).
  - MULDIV_DIV_CYCLES constant.
- Sub-module muldiv_div_core: the iterative restoring divider, covering the remainder/quotient registers, counter and sign fix. It has a start/done handshake with the controller.
- The multiplier stays inline, as one synthesizable `*`.

## Test plan
- MUL 7 × 0xFFFFFFFD → result 0xFFFFFFEB, resultValid at cycle 2; busy high cycles 0–1.
- MULH/MULHSU/MULHU with 0xFFFFFFFF × 2 → 0xFFFFFFFF / 0xFFFFFFFF / 0x00000001.
- DIV 0xFFFFFFF9(-7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14, REMU → 2; each resultValid at cycle 33.
- Special cases: DIV x/0 → 0xFFFFFFFF, REMU 5/0 → 5, DIV 0x80000000/-1 → 0x80000000, REM same → 0; all resultValid at cycle 1.
- Flush at cycle 10 of a DIV → IDLE at cycle 11, no pulse. A new MUL issued at cycle 11 → result at cycle 13.
- rstN low at cycle 5 of a DIV → busy=0, resultValid=0, result=0 immediately; no pulse after release.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_unit_pkg : shared op codes, FSM states and helpers for muldiv_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  localparam int MULDIV_DIV_CYCLES = 32;

  function automatic logic is_mul_op(input muldiv_code_e code);
    return (code == MD_MUL) || (code == MD_MULH) || (code == MD_MULHSU) || (code == MD_MULHU);
  endfunction

  function automatic logic is_rem_op(input muldiv_code_e code);
    return (code == MD_REM) || (code == MD_REMU);
  endfunction

  function automatic logic is_signed_div(input muldiv_code_e code);
    return (code == MD_DIV) || (code == MD_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_div_core : iterative restoring divider, one quotient bit per step
// Revision: 1.0
// ---------------------------------------------------------------------------
module muldiv_div_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic                  step,
  input  logic                  is_signed,
  input  logic                  want_rem,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]         cnt_q;
  logic                  neg_quo_q, neg_rem_q, sel_rem_q;

  logic                  neg_a, neg_b;
  logic [DATA_WIDTH-1:0] abs_a, abs_b;
  logic [DATA_WIDTH:0]   shifted;
  logic                  fits;
  logic [DATA_WIDTH-1:0] rem_nx, quo_nx, quo_fix, rem_fix;

  assign neg_a = is_signed && dividend[DATA_WIDTH-1];
  assign neg_b = is_signed && divisor[DATA_WIDTH-1];
  assign abs_a = neg_a ? ('0 - dividend) : dividend;
  assign abs_b = neg_b ? ('0 - divisor) : divisor;

  // Comparing before subtracting keeps the trial difference at W bits.
  always_comb begin
    shifted = {rem_q, quo_q[DATA_WIDTH-1]};
    fits    = shifted >= {1'b0, dvs_q};
    rem_nx  = fits ? (shifted[DATA_WIDTH-1:0] - dvs_q) : shifted[DATA_WIDTH-1:0];
    quo_nx  = {quo_q[DATA_WIDTH-2:0], fits};
  end

  assign quo_fix = neg_quo_q ? ('0 - quo_nx) : quo_nx;
  assign rem_fix = neg_rem_q ? ('0 - rem_nx) : rem_nx;
  assign result  = sel_rem_q ? rem_fix : quo_fix;
  assign done    = step && (cnt_q == '0);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else if (start) begin
      rem_q     <= '0;
      quo_q     <= abs_a;
      dvs_q     <= abs_b;
      cnt_q     <= CW'(DATA_WIDTH - 1);
      neg_quo_q <= neg_a ^ neg_b;
      neg_rem_q <= neg_a;
      sel_rem_q <= want_rem;
    end else if (step) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_unit : RV32M multiply/divide execution unit with pipeline stall
// Revision: 1.0
// ---------------------------------------------------------------------------
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = MULDIV_DIV_CYCLES
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  reqValid,
  input  muldiv_code_e          reqCode,
  input  logic [DATA_WIDTH-1:0] srcA,
  input  logic [DATA_WIDTH-1:0] srcB,
  input  logic                  flush,
  output logic                  busy,
  output logic                  resultValid,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  muldiv_state_e         state;
  muldiv_code_e          code_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;

  logic                  accept, div_by_zero, sgn_ovf, special, div_start, div_step, div_done;
  logic [DATA_WIDTH-1:0] special_value, div_value, mul_value;
  logic                  a_sx, b_sx;
  logic [2*DATA_WIDTH-1:0] a_ext, b_ext, product;

  assign accept      = (state == ST_IDLE) && reqValid && !flush;
  assign div_by_zero = (srcB == '0);
  assign sgn_ovf     = is_signed_div(reqCode) && (srcA == MIN_NEG) && (srcB == ALL_ONES);
  assign special     = !is_mul_op(reqCode) && (div_by_zero || sgn_ovf);
  assign div_start   = accept && !is_mul_op(reqCode) && !special;
  assign div_step    = (state == ST_DIV) && !flush;

  always_comb begin
    special_value = '0;
    if (div_by_zero) special_value = is_rem_op(reqCode) ? srcA : ALL_ONES;
    else             special_value = is_rem_op(reqCode) ? '0 : MIN_NEG;
  end

  // Sign-extending to 2W and multiplying modulo 2^2W yields the exact signed product.
  assign a_sx      = ((code_q == MD_MULH) || (code_q == MD_MULHSU)) && a_q[DATA_WIDTH-1];
  assign b_sx      = (code_q == MD_MULH) && b_q[DATA_WIDTH-1];
  assign a_ext     = {{DATA_WIDTH{a_sx}}, a_q};
  assign b_ext     = {{DATA_WIDTH{b_sx}}, b_q};
  assign product   = a_ext * b_ext;
  assign mul_value = (code_q == MD_MUL) ? product[DATA_WIDTH-1:0]
                                        : product[2*DATA_WIDTH-1:DATA_WIDTH];

  muldiv_div_core #(.DATA_WIDTH(DATA_WIDTH)) u_div_core (
    .clk       (clk),
    .rstN      (rstN),
    .start     (div_start),
    .step      (div_step),
    .is_signed (is_signed_div(reqCode)),
    .want_rem  (is_rem_op(reqCode)),
    .dividend  (srcA),
    .divisor   (srcB),
    .done      (div_done),
    .result    (div_value)
  );

  assign busy = (state == ST_IDLE) ? (reqValid && !flush) : (state != ST_DONE);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= ST_IDLE;
      code_q      <= MD_MUL;
      a_q         <= '0;
      b_q         <= '0;
      result      <= '0;
      resultValid <= 1'b0;
    end else begin
      resultValid <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (reqValid) begin
              code_q <= reqCode;
              a_q    <= srcA;
              b_q    <= srcB;
              if (special) begin
                result      <= special_value;
                resultValid <= 1'b1;
                state       <= ST_DONE;
              end else if (is_mul_op(reqCode)) begin
                state <= ST_MUL;
              end else begin
                state <= ST_DIV;
              end
            end
          end
          ST_MUL: begin
            result      <= mul_value;
            resultValid <= 1'b1;
            state       <= ST_DONE;
          end
          ST_DIV: begin
            if (div_done) begin
              result      <= div_value;
              resultValid <= 1'b1;
              state       <= ST_DONE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_muldiv_unit : randomized self-checking bench with a latency/arithmetic model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic         clk = 1'b0;
  logic         rstN = 1'b1;
  logic         reqValid = 1'b0;
  muldiv_code_e reqCode = MD_MUL;
  logic [31:0]  srcA = '0;
  logic [31:0]  srcB = '0;
  logic         flush = 1'b0;
  logic         busy, resultValid;
  logic [31:0]  result;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .reqValid    (reqValid),
    .reqCode     (reqCode),
    .srcA        (srcA),
    .srcB        (srcB),
    .flush       (flush),
    .busy        (busy),
    .resultValid (resultValid),
    .result      (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an RV32M op, from plain integer arithmetic.
  function automatic logic [31:0] exp_value(input muldiv_code_e c, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'b0, a});
    longint      ub = longint'({32'b0, b});
    longint      p  = 0;
    logic [63:0] pu = 64'({32'b0, a}) * 64'({32'b0, b});
    bit          ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (c)
      MD_MUL:    begin p = sa * sb; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  return pu[63:32];
      MD_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; if (ovf) return a; p = sa / sb; return p[31:0]; end
      MD_REM:    begin if (b == 0) return a; if (ovf) return 32'h0; p = sa % sb; return p[31:0]; end
      MD_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      default:   begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  // Cycle (relative to accept) in which resultValid must pulse.
  function automatic int exp_lat(input muldiv_code_e c, input logic [31:0] a, input logic [31:0] b);
    if (c inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU}) return 2;
    if (b == 0) return 1;
    if ((c inside {MD_DIV, MD_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Reference model: a countdown to the pulse plus the value it must carry.
  bit          m_active = 1'b0;
  bit          m_valid  = 1'b0;
  int          m_cnt    = 0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pend   = '0;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_active <= 1'b0;
      m_valid  <= 1'b0;
      m_cnt    <= 0;
      m_result <= '0;
    end else if (flush) begin
      m_active <= 1'b0;
      m_valid  <= 1'b0;
    end else if (m_valid) begin
      m_valid <= 1'b0;
    end else if (m_active) begin
      if (m_cnt == 1) begin
        m_active <= 1'b0;
        m_valid  <= 1'b1;
        m_result <= m_pend;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (reqValid) begin
      if (exp_lat(reqCode, srcA, srcB) == 1) begin
        m_valid  <= 1'b1;
        m_result <= exp_value(reqCode, srcA, srcB);
      end else begin
        m_active <= 1'b1;
        m_cnt    <= exp_lat(reqCode, srcA, srcB) - 1;
        m_pend   <= exp_value(reqCode, srcA, srcB);
      end
    end
  end

  logic exp_busy;
  always @(negedge clk) begin
    if (check_en) begin
      exp_busy = m_active || (!m_valid && reqValid && !flush);
      check("busy", 32'(busy), 32'(exp_busy));
      check("resultValid", 32'(resultValid), 32'(m_valid));
      check("result", result, m_result);
    end
  end

  // Issue one op at posedge+1 and hold it while stalled; optionally kill it at cycle flush_at.
  task automatic run_op(input muldiv_code_e c, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, output bit got, output int lat, output logic [31:0] res);
    int cyc = 0;
    got = 1'b0;
    lat = -1;
    res = '0;
    reqValid = 1'b1;
    reqCode  = c;
    srcA     = a;
    srcB     = b;
    flush    = (flush_at == 0);
    forever begin
      @(negedge clk);
      if (resultValid) begin
        got = 1'b1;
        lat = cyc;
        res = result;
        break;
      end
      if (flush) break;
      cyc++;
      if (cyc > 60) begin
        n_vec++;
        n_err++;
        $display("FAIL run_op_timeout: got no resultValid, expected one within 60 cycles");
        break;
      end
      @(posedge clk);
      #1;
      flush = (cyc == flush_at);
    end
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic directed(input string name, input muldiv_code_e c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc);
    bit got;
    int lat;
    logic [31:0] res;
    run_op(c, a, b, -1, got, lat, res);
    check({name, "_value"}, res, exp_res);
    check({name, "_cycle"}, 32'(lat), 32'(exp_cyc));
  endtask

  initial begin
    bit          got;
    int          lat;
    int          pulses;
    int          fa;
    int          sel;
    logic [31:0] res, a, b;
    muldiv_code_e c;

    #1 rstN = 1'b0;
    #1 check_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 32'h0);
    check("reset_valid", 32'(resultValid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rstN = 1'b1;

    check("model_mulhsu", exp_value(MD_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("model_div", exp_value(MD_DIV, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFD);
    check("model_lat", 32'(exp_lat(MD_DIVU, 32'd100, 32'd7)), 32'd33);

    directed("mul",      MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    directed("mulh",     MD_MULH,   32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 2);
    directed("mulhsu",   MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 2);
    directed("mulhu",    MD_MULHU,  32'hFFFF_FFFF,  32'd2,         32'h0000_0001, 2);
    directed("div",      MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    directed("rem",      MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    directed("divu",     MD_DIVU,   32'd100,        32'd7,         32'd14,        33);
    directed("remu",     MD_REMU,   32'd100,        32'd7,         32'd2,         33);
    directed("div_zero", MD_DIV,    32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1);
    directed("remu_zero",MD_REMU,   32'd5,          32'd0,         32'd5,         1);
    directed("div_ovf",  MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    directed("rem_ovf",  MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1);

    // A DIV killed at cycle 10 must not pulse; a MUL issued at cycle 11 retires at cycle 13.
    run_op(MD_DIV, 32'd1000, 32'd3, 10, got, lat, res);
    check("flush_no_pulse", 32'(got), 32'h0);
    directed("mul_after_flush", MD_MUL, 32'd6, 32'd9, 32'd54, 2);

    // Reset asserted at cycle 5 of a DIV.
    reqValid = 1'b1;
    reqCode  = MD_DIV;
    srcA     = 32'hFFFF_FFF9;
    srcB     = 32'd2;
    repeat (5) @(posedge clk);
    #1;
    rstN     = 1'b0;
    reqValid = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_valid", 32'(resultValid), 32'h0);
    check("rst_mid_result", result, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rstN   = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (resultValid) pulses++;
    end
    check("rst_no_pulse", 32'(pulses), 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 200; i++) begin
      c   = muldiv_code_e'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
      else if (sel == 3) begin a = 32'h0 - 32'($urandom_range(1, 300)); b = $urandom_range(1, 20); end
      fa = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 36) : -1;
      run_op(c, a, b, fa, got, lat, res);
      if (got) begin
        check("rand_value", res, exp_value(c, a, b));
        check("rand_cycle", 32'(lat), 32'(exp_lat(c, a, b)));
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
